beam_thresh_sequencer: RTL

- Controller for an array of NBEAMS/2 dual-beam DSP threshold/trigger slices.
- Each slice has two 18-bit staging threshold registers, loaded by individual clock enables from a shared threshold bus, and one common update strobe that moves both staged values into the active thresholds.
- This block accepts per-beam threshold writes over a valid/ready port and drives the shared bus and one-hot staging enables.
- It sequences a single global update pulse so that all beams switch thresholds on the same clock.

---
 rtl/beam_thresh_sequencer.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/beam_thresh_sequencer.sv
// -----------------------------------------------------------------------------
// beam_thresh_sequencer
//
// Controller for an array of NBEAMS/2 dual-beam threshold/trigger slices.
// Per-beam threshold writes arrive on a valid/ready port and are forwarded on
// a shared 18-bit threshold bus together with a one-hot staging enable (or all
// enables for a broadcast). A single global update strobe commits every
// slice's staged thresholds on the same clock. The sequencer guarantees that
// no staging enable coincides with, or directly follows, the update strobe.
//
// Optional feature (macro BEAM_THRESH_SHADOW_EN):
//   When defined, a staged/active shadow copy of every beam threshold is kept
//   and the committed value can be read back on rd_addr_i/rd_data_o with one
//   cycle of latency. When undefined, rd_data_o is tied to zero.
//
// Ports:
//   clk_i         system clock
//   rst_i         synchronous active-high reset
//   wr_addr_i     beam index of a threshold write; all-ones = broadcast
//   wr_data_i     threshold value
//   wr_valid_i    write request
//   wr_ready_o    write accepted when wr_valid_i & wr_ready_o
//   update_req_i  request to commit all staged thresholds
//   update_ack_o  one-cycle pulse coincident with update_o
//   thresh_o      shared threshold bus to all slices
//   thresh_ce_o   staging enables; bit 2k+1 / 2k = slice k upper / lower lane
//   update_o      common update strobe to all slices
//   dirty_o       staged writes not yet committed
//   addr_err_o    sticky out-of-range write address flag
//   rd_addr_i     shadow readback address
//   rd_data_o     committed threshold of rd_addr_i (shadow build only)
// -----------------------------------------------------------------------------
module beam_thresh_sequencer #(
  parameter int NBEAMS    = 48,
  parameter int ADDR_BITS = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_BITS-1:0] wr_addr_i,
  input  logic [17:0]          wr_data_i,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  input  logic                 update_req_i,
  output logic                 update_ack_o,
  output logic [17:0]          thresh_o,
  output logic [NBEAMS-1:0]    thresh_ce_o,
  output logic                 update_o,
  output logic                 dirty_o,
  output logic                 addr_err_o,
  input  logic [ADDR_BITS-1:0] rd_addr_i,
  output logic [17:0]          rd_data_o
);

  localparam logic [ADDR_BITS-1:0] ADDR_BCAST = {ADDR_BITS{1'b1}};
  localparam logic [ADDR_BITS-1:0] NBEAMS_A   = ADDR_BITS'(NBEAMS);
  localparam logic [NBEAMS-1:0]    CE_NONE    = {NBEAMS{1'b0}};
  localparam logic [NBEAMS-1:0]    CE_ALL     = {NBEAMS{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_UPD   = 2'd1,
    ST_GUARD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               pending_q, pending_d;
  logic               ready_q, ready_d;
  logic [17:0]        thresh_q, thresh_d;
  logic [NBEAMS-1:0]  ce_q, ce_d;
  logic               update_q, update_d;
  logic               dirty_q, dirty_d;
  logic               addr_err_q, addr_err_d;
  logic               wr_accept;
  logic               upd_fire;

  // Ready is forced low while reset is asserted so the port never accepts a
  // write that the reset would discard; ready_q itself resets to 1 so the
  // port opens on the first cycle after reset.
  assign wr_ready_o   = ready_q & ~rst_i;
  assign thresh_o     = thresh_q;
  assign thresh_ce_o  = ce_q;
  assign update_o     = update_q;
  assign update_ack_o = update_q;
  assign dirty_o      = dirty_q;
  assign addr_err_o   = addr_err_q;

  // Next-state logic: write decode, update sequencing and registered outputs.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    thresh_d   = thresh_q;
    ce_d       = CE_NONE;
    dirty_d    = dirty_q;
    addr_err_d = addr_err_q;
    wr_accept  = wr_valid_i & wr_ready_o;
    // In UPD the commit fires on the first cycle with no enable on the bus,
    // so a write staged together with the request lands before the commit.
    upd_fire   = (state_q == ST_UPD) && (ce_q == CE_NONE);

    if (wr_accept) begin
      if (wr_addr_i == ADDR_BCAST) begin
        ce_d     = CE_ALL;
        thresh_d = wr_data_i;
        dirty_d  = 1'b1;
      end else if (wr_addr_i < NBEAMS_A) begin
        for (int i = 0; i < NBEAMS; i++) begin
          ce_d[i] = (wr_addr_i == ADDR_BITS'(i));
        end
        thresh_d = wr_data_i;
        dirty_d  = 1'b1;
      end else begin
        // Accepted and dropped; only the sticky error flag records it.
        addr_err_d = 1'b1;
      end
    end else begin
      ce_d = CE_NONE;
    end

    case (state_q)
      ST_IDLE: begin
        if (update_req_i || pending_q) begin
          state_d = ST_UPD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_UPD: begin
        if (upd_fire) begin
          state_d   = ST_GUARD;
          dirty_d   = 1'b0;
          // A request arriving on the commit cycle itself still needs its
          // own commit later; earlier ones are covered by this one.
          pending_d = update_req_i;
        end else begin
          state_d   = ST_UPD;
          pending_d = pending_q | update_req_i;
        end
      end
      ST_GUARD: begin
        state_d   = ST_IDLE;
        pending_d = pending_q | update_req_i;
      end
      default: begin
        state_d   = ST_IDLE;
        pending_d = 1'b0;
      end
    endcase

    // Outputs are precomputed from the next state so they are registered.
    update_d = (state_d == ST_UPD) && (ce_d == CE_NONE);
    // A pending commit keeps the port closed through the idle pass-through.
    ready_d  = (state_d == ST_IDLE) && !pending_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      pending_q  <= 1'b0;
      ready_q    <= 1'b1;
      thresh_q   <= 18'd0;
      ce_q       <= CE_NONE;
      update_q   <= 1'b0;
      dirty_q    <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      ready_q    <= ready_d;
      thresh_q   <= thresh_d;
      ce_q       <= ce_d;
      update_q   <= update_d;
      dirty_q    <= dirty_d;
      addr_err_q <= addr_err_d;
    end
  end

`ifdef BEAM_THRESH_SHADOW_EN
  logic [17:0] stage_q  [NBEAMS];
  logic [17:0] stage_d  [NBEAMS];
  logic [17:0] active_q [NBEAMS];
  logic [17:0] active_d [NBEAMS];
  logic [17:0] rd_q, rd_d;

  assign rd_data_o = rd_q;

  // Shadow mirrors the slices: stage on the bus enables, commit on update.
  always_comb begin
    for (int i = 0; i < NBEAMS; i++) begin
      if (ce_q[i]) begin
        stage_d[i] = thresh_q;
      end else begin
        stage_d[i] = stage_q[i];
      end
      if (update_q) begin
        active_d[i] = stage_q[i];
      end else begin
        active_d[i] = active_q[i];
      end
    end
    if (rd_addr_i < NBEAMS_A) begin
      rd_d = active_q[rd_addr_i];
    end else begin
      rd_d = 18'd0;
    end
  end

  // Shadow storage and readback register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NBEAMS; i++) begin
        stage_q[i]  <= 18'd0;
        active_q[i] <= 18'd0;
      end
      rd_q <= 18'd0;
    end else begin
      stage_q  <= stage_d;
      active_q <= active_d;
      rd_q     <= rd_d;
    end
  end
`else
  logic rd_addr_unused;

  assign rd_addr_unused = ^rd_addr_i;
  assign rd_data_o      = 18'd0;
`endif

endmodule
